ram_bist_ctrl: RTL

//  Initiator side of the single-port RAM interface (data/addr/we -> q): a built-in self-test sequencer.
//  On start it runs a 4-phase march: W0 writes pattern, R0 reads/compares, W1 writes inverse, R1 reads/compares.

---
 rtl/ram_bist_ctrl_pkg.sv | 27 ++
 rtl/ram_bist_ctrl_rd_pipe.sv | 45 ++++
 rtl/ram_bist_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ram_bist_ctrl_pkg.sv
// State encoding and phase helpers for the RAM march BIST sequencer.
// Pure definitions: no latency, no flow control.
package ram_bist_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0,
    ST_R0,
    ST_W1,
    ST_R1,
    ST_DONE
  } state_t;

  // Second half of the march works on the inverted pattern.
  function automatic logic phase_inv(input state_t s);
    return (s == ST_W1) || (s == ST_R1);
  endfunction

  function automatic logic is_write(input state_t s);
    return (s == ST_W0) || (s == ST_W1);
  endfunction

  function automatic logic is_read(input state_t s);
    return (s == ST_R0) || (s == ST_R1);
  endfunction

endpackage

// File: rtl/ram_bist_ctrl_rd_pipe.sv
// Delay line for issued reads: {valid, addr, expected} emerge RD_LAT edges after entry.
// Fixed RD_LAT latency; no backpressure, one entry accepted per cycle.
module ram_bist_ctrl_rd_pipe #(
  parameter int RD_LAT     = 2,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_exp,
  output logic                  out_vld,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_exp
);

  logic [RD_LAT-1:0]     vld_q;
  logic [ADDR_WIDTH-1:0] addr_q [RD_LAT];
  logic [DATA_WIDTH-1:0] exp_q  [RD_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      vld_q[0]  <= in_vld;
      addr_q[0] <= in_addr;
      exp_q[0]  <= in_exp;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[RD_LAT-1];
  assign out_addr = addr_q[RD_LAT-1];
  assign out_exp  = exp_q[RD_LAT-1];

endmodule

// File: rtl/ram_bist_ctrl.sv
// March BIST sequencer (W0,R0,W1,R1) driving a single-port RAM; registered outputs lag state by one edge.
// Run takes 4*DEPTH+2*RD_LAT+1 edges from start to done; start is ignored while a run is active.
module ram_bist_ctrl
  import ram_bist_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 64,
  parameter int                    RD_LAT     = 2,
  parameter logic [DATA_WIDTH-1:0] SEED       = '0,
  parameter int                    CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);

  localparam int            CW        = ADDR_WIDTH + 2 + $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] WR_LAST   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(DEPTH + RD_LAT - 1);
  localparam logic [CW-1:0] ISSUE_END = CW'(DEPTH);

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  wr, issue;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_pat;
  logic                  p_vld;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [DATA_WIDTH-1:0] p_exp;
  logic                  mism;
  logic [CNT_WIDTH-1:0]  err_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Read phases run DEPTH issue cycles then RD_LAT drain cycles on the same counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = ST_W0;
      end
      ST_W0, ST_W1: begin
        if (cnt == WR_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (state == ST_W0) ? ST_R0 : ST_R1;
        end
      end
      ST_R0, ST_R1: begin
        if (cnt == RD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (state == ST_R0) ? ST_W1 : ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wr       = is_write(state);
    issue    = is_read(state) && (cnt < ISSUE_END);
    cur_addr = cnt[ADDR_WIDTH-1:0];
    cur_pat  = DATA_WIDTH'(cur_addr) ^ SEED ^ {DATA_WIDTH{phase_inv(state)}};
  end

  // Pipe entry shares the edge that drives ram_addr, so its output lines up with valid ram_q.
  ram_bist_ctrl_rd_pipe #(
    .RD_LAT     (RD_LAT),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (issue),
    .in_addr  (cur_addr),
    .in_exp   (cur_pat),
    .out_vld  (p_vld),
    .out_addr (p_addr),
    .out_exp  (p_exp)
  );

  always_comb begin
    mism    = p_vld && (ram_q != p_exp);
    err_nxt = err_count;
    if (mism && (err_count != {CNT_WIDTH{1'b1}})) err_nxt = err_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      ram_we   <= wr;
      ram_addr <= (wr || issue) ? cur_addr : '0;
      ram_data <= wr ? cur_pat : '0;
      busy     <= is_write(state) || is_read(state);
      done     <= (state == ST_DONE);
      if ((state == ST_IDLE) && start) begin
        err_count <= '0;
        fail_addr <= '0;
        fail_data <= '0;
        pass      <= 1'b0;
      end else begin
        err_count <= err_nxt;
        if (mism && (err_count == '0)) begin
          fail_addr <= p_addr;
          fail_data <= ram_q;
        end
        if (state == ST_DONE) pass <= (err_nxt == '0);
      end
    end
  end

endmodule
